// File: rtl/adam_pause_seq.sv
// adam_pause_seq: ordered pause/resume sequencer for a chain of units.
// Pauses stages in ascending order and resumes them in descending order,
// exposing one upstream pause_req/pause_ack pair. A per-stage watchdog
// latches the first stage that fails to answer within TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   pause_req          upstream request to pause all stages
//   pause_ack          all stages paused, in order
//   stage_pause_req    per-unit pause request (always a prefix)
//   stage_pause_ack    per-unit pause acknowledge
//   busy               a pause or resume sequence is in progress
//   timeout            sticky: some stage wait exceeded TIMEOUT_CYCLES
//   timeout_stage      index of the first stage that timed out
module adam_pause_seq #(
    parameter int unsigned NO_STAGES      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned IDX_WIDTH      = $clog2((NO_STAGES > 2) ? NO_STAGES : 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause_req,
    output logic                 pause_ack,
    output logic                 stage_pause_req [NO_STAGES],
    input  logic                 stage_pause_ack [NO_STAGES],
    output logic                 busy,
    output logic                 timeout,
    output logic [IDX_WIDTH-1:0] timeout_stage
);

    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NO_STAGES - 1);
    localparam logic [IDX_WIDTH-1:0] ZERO_IDX = '0;
    localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]     TO_LIMIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic                 WDOG_EN  = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_RUNNING,
        ST_PAUSING,
        ST_PAUSED,
        ST_RESUMING
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [NO_STAGES-1:0]   req_q, req_d;
    logic                   pause_ack_q, pause_ack_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    logic [IDX_WIDTH-1:0]   timeout_stage_q, timeout_stage_d;

    logic                   cur_ack;
    logic                   waiting;

    // Return v with bit k replaced by b (loop avoids out-of-range selects).
    function automatic logic [NO_STAGES-1:0] with_bit(
        input logic [NO_STAGES-1:0] v,
        input logic [IDX_WIDTH-1:0] k,
        input logic                 b
    );
        logic [NO_STAGES-1:0] r;
        r = v;
        for (int unsigned i = 0; i < NO_STAGES; i++) begin
            if (k == IDX_WIDTH'(i)) begin
                r[i] = b;
            end
        end
        return r;
    endfunction

    // Acknowledge of the stage currently being awaited.
    always_comb begin
        cur_ack = 1'b0;
        for (int unsigned i = 0; i < NO_STAGES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                cur_ack = stage_pause_ack[i];
            end
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUNNING;
            idx_q           <= '0;
            req_q           <= '0;
            pause_ack_q     <= 1'b0;
            busy_q          <= 1'b0;
            wait_cnt_q      <= '0;
            timeout_q       <= 1'b0;
            timeout_stage_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            req_q           <= req_d;
            pause_ack_q     <= pause_ack_d;
            busy_q          <= busy_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_q       <= timeout_d;
            timeout_stage_q <= timeout_stage_d;
        end
    end

    // Next-state, request prefix, watchdog.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        req_d           = req_q;
        pause_ack_d     = pause_ack_q;
        wait_cnt_d      = '0;
        timeout_d       = timeout_q;
        timeout_stage_d = timeout_stage_q;
        waiting         = 1'b0;

        unique case (state_q)
            ST_RUNNING: begin
                req_d       = '0;
                pause_ack_d = 1'b0;
                if (pause_req) begin
                    state_d = ST_PAUSING;
                    idx_d   = ZERO_IDX;
                    req_d   = with_bit('0, ZERO_IDX, 1'b1);
                end
            end

            ST_PAUSING: begin
                // Abort takes priority over a simultaneous ack.
                if (!pause_req) begin
                    state_d = ST_RESUMING;
                    req_d   = with_bit(req_q, idx_q, 1'b0);
                end else if (cur_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_PAUSED;
                        pause_ack_d = 1'b1;
                    end else begin
                        idx_d = idx_q + ONE_IDX;
                        req_d = with_bit(req_q, idx_q + ONE_IDX, 1'b1);
                    end
                end else begin
                    waiting = 1'b1;
                end
            end

            ST_PAUSED: begin
                pause_ack_d = 1'b1;
                if (!pause_req) begin
                    state_d     = ST_RESUMING;
                    idx_d       = LAST_IDX;
                    req_d       = with_bit(req_q, LAST_IDX, 1'b0);
                    pause_ack_d = 1'b0;
                end
            end

            ST_RESUMING: begin
                if (pause_req) begin
                    state_d = ST_PAUSING;
                    req_d   = with_bit(req_q, idx_q, 1'b1);
                end else if (!cur_ack) begin
                    if (idx_q == ZERO_IDX) begin
                        state_d = ST_RUNNING;
                    end else begin
                        idx_d = idx_q - ONE_IDX;
                        req_d = with_bit(req_q, idx_q - ONE_IDX, 1'b0);
                    end
                end else begin
                    waiting = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUNNING;
                req_d   = '0;
            end
        endcase

        // Counter only runs while stalled on the same stage and direction;
        // any transition leaves it at the cleared default.
        if (waiting) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? CNT_MAX : (wait_cnt_q + CNT_W'(1));
            if (WDOG_EN && (wait_cnt_q == TO_LIMIT)) begin
                timeout_d = 1'b1;
                if (!timeout_q) begin
                    timeout_stage_d = idx_q;
                end
            end
        end

        busy_d = (state_d == ST_PAUSING) || (state_d == ST_RESUMING);
    end

    // Unpack the request register onto the per-unit port.
    always_comb begin
        for (int unsigned i = 0; i < NO_STAGES; i++) begin
            stage_pause_req[i] = req_q[i];
        end
    end

    assign pause_ack     = pause_ack_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;
    assign timeout_stage = timeout_stage_q;

    // Requests must always form a contiguous prefix from stage 0.
    for (genvar g = 1; g < NO_STAGES; g++) begin : g_prefix_chk
        a_prefix : assert property (@(posedge clk) disable iff (rst)
            req_q[g] |-> req_q[g-1]);
    end

endmodule
